// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file geometry and the
// status-flag bit positions used by both the ALU and the operand register file.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NREGS      = 8;
    localparam int FLAG_W     = 4;

    // Bit positions inside the 4-bit status word {V,C,N,Z}
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic v, input logic c,
                                          input logic n, input logic z);
        flags_t f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/status_reg.sv
// Enable-loaded status flag register with synchronous active-low reset.
// Output is purely registered; there is no path from D to Q within a cycle.
module status_reg
    import cpu_pkg::*;
(
    input  logic   Clk,
    input  logic   Rst_n,
    input  logic   Load,
    input  flags_t D,
    output flags_t Q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its inputs as they were before the edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Q <= '0;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/alu_operand_regfile.sv
// Register file and status stage around the 16-bit ALU: registered operand
// fetch with write-first bypass, result writeback, and the ALU flag register.
module alu_operand_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int NREGS   = cpu_pkg::NREGS,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  RdEn,
    input  logic [REG_ADDR_W-1:0] RdAddrA,
    input  logic [REG_ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0]     OpA,
    output logic [DATA_W-1:0]     OpB,
    output logic                  OpValid,
    input  logic                  WrEn,
    input  logic [REG_ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0]     WrData,
    input  logic                  FlagEn,
    input  logic                  V,
    input  logic                  C,
    input  logic                  N,
    input  logic                  Z,
    output logic [FLAG_W-1:0]     Flags
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              wr_commit;

    // A hardwired-zero R0 never takes a write, so it can never be a bypass source either.
    assign wr_commit = WrEn && !(ZERO_R0 && WrAddr == '0);

    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned, which is what would otherwise infer a latch.
    always_comb begin
        rd_a = regs[RdAddrA];
        if (ZERO_R0 && RdAddrA == '0) begin
            rd_a = '0;
        end else if (wr_commit && WrAddr == RdAddrA) begin
            rd_a = WrData;
        end
    end

    always_comb begin
        rd_b = regs[RdAddrB];
        if (ZERO_R0 && RdAddrB == '0) begin
            rd_b = '0;
        end else if (wr_commit && WrAddr == RdAddrB) begin
            rd_b = WrData;
        end
    end

    // NOTE: the register array is reset here because the architecture requires all
    // registers to read 0 after reset; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            OpA     <= '0;
            OpB     <= '0;
            OpValid <= 1'b0;
        end else begin
            if (wr_commit) begin
                regs[WrAddr] <= WrData;
            end
            OpValid <= RdEn;
            if (RdEn) begin
                OpA <= rd_a;
                OpB <= rd_b;
            end
        end
    end

    // Flags load independently of writeback so compare-style ops can update status alone.
    status_reg u_status_reg (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Load  (FlagEn),
        .D     (pack_flags(V, C, N, Z)),
        .Q     (Flags)
    );

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed, table-driven bench for alu_operand_regfile: each record drives one
// clock edge and lists the operand/flag outputs expected just after that edge.
module tb_alu_operand_regfile;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flag_en;
    logic        v, c, n, z;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        rd_en;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        wr_en;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        flag_en;
        logic [3:0]  vcnz;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_valid;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    alu_operand_regfile dut (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .RdEn    (rd_en),
        .RdAddrA (rd_addr_a),
        .RdAddrB (rd_addr_b),
        .OpA     (op_a),
        .OpB     (op_b),
        .OpValid (op_valid),
        .WrEn    (wr_en),
        .WrAddr  (wr_addr),
        .WrData  (wr_data),
        .FlagEn  (flag_en),
        .V       (v),
        .C       (c),
        .N       (n),
        .Z       (z),
        .Flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic rst, logic rd, logic [2:0] ra, logic [2:0] rb,
                                logic wr, logic [2:0] wa, logic [15:0] wd,
                                logic fe, logic [3:0] vcnz,
                                logic [15:0] ea, logic [15:0] eb, logic ev, logic [3:0] ef);
        vec_t t;
        t.name = name; t.rst_n = rst; t.rd_en = rd; t.ra = ra; t.rb = rb;
        t.wr_en = wr; t.wa = wa; t.wd = wd; t.flag_en = fe; t.vcnz = vcnz;
        t.exp_a = ea; t.exp_b = eb; t.exp_valid = ev; t.exp_flags = ef;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 time unit later.
    task automatic apply(input vec_t t);
        @(negedge clk);
        rst_n     = t.rst_n;
        rd_en     = t.rd_en;
        rd_addr_a = t.ra;
        rd_addr_b = t.rb;
        wr_en     = t.wr_en;
        wr_addr   = t.wa;
        wr_data   = t.wd;
        flag_en   = t.flag_en;
        {v, c, n, z} = t.vcnz;
        @(posedge clk);
        #1;
        check({t.name, ".OpA"},     op_a,            t.exp_a);
        check({t.name, ".OpB"},     op_b,            t.exp_b);
        check({t.name, ".OpValid"}, {15'd0, op_valid}, {15'd0, t.exp_valid});
        check({t.name, ".Flags"},   {12'd0, flags},  {12'd0, t.exp_flags});
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; flag_en = 1'b0;
        {v, c, n, z} = 4'b0000;

        //          name          rst rd ra rb wr wa wd        fe vcnz     expA      expB      ev ef
        vecs.push_back(mk("rst0",      0, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000));
        vecs.push_back(mk("rst1",      0, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000));
        vecs.push_back(mk("idle",      1, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000));
        vecs.push_back(mk("rd_r1r2",   1, 1, 1, 2, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000));
        vecs.push_back(mk("rd_r3r4",   1, 1, 3, 4, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000));
        vecs.push_back(mk("rd_r5r6",   1, 1, 5, 6, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000));
        vecs.push_back(mk("rd_r7r0",   1, 1, 7, 0, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000));
        vecs.push_back(mk("wr_r1",     1, 0, 0, 0, 1, 1, 16'd12,   0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000));
        vecs.push_back(mk("wr_r2",     1, 0, 0, 0, 1, 2, 16'd5,    0, 4'b0000, 16'h0000, 16'h0000, 0, 4'b0000));
        vecs.push_back(mk("read12",    1, 1, 1, 2, 0, 0, 16'h0000, 0, 4'b0000, 16'd12,   16'd5,    1, 4'b0000));
        vecs.push_back(mk("hold",      1, 0, 3, 4, 0, 0, 16'h0000, 0, 4'b0000, 16'd12,   16'd5,    0, 4'b0000));
        vecs.push_back(mk("byp_r3",    1, 1, 3, 3, 1, 3, 16'h0011, 0, 4'b0000, 16'h0011, 16'h0011, 1, 4'b0000));
        vecs.push_back(mk("rd_r3",     1, 1, 3, 1, 0, 0, 16'h0000, 0, 4'b0000, 16'h0011, 16'd12,   1, 4'b0000));
        vecs.push_back(mk("r0_wr",     1, 1, 0, 2, 1, 0, 16'hFFFF, 0, 4'b0000, 16'h0000, 16'd5,    1, 4'b0000));
        vecs.push_back(mk("r0_rd",     1, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000));
        vecs.push_back(mk("flag_ld",   1, 0, 0, 0, 0, 0, 16'h0000, 1, 4'b0101, 16'h0000, 16'h0000, 0, 4'b0101));
        vecs.push_back(mk("flag_hold", 1, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b1111, 16'h0000, 16'h0000, 0, 4'b0101));
        vecs.push_back(mk("byp_b",     1, 1, 1, 5, 1, 5, 16'hBEEF, 0, 4'b1111, 16'd12,   16'hBEEF, 1, 4'b0101));
        vecs.push_back(mk("wr_flag",   1, 0, 0, 0, 1, 6, 16'h0F0F, 1, 4'b1000, 16'd12,   16'hBEEF, 0, 4'b1000));
        vecs.push_back(mk("rd_r6",     1, 1, 6, 6, 0, 0, 16'h0000, 0, 4'b0000, 16'h0F0F, 16'h0F0F, 1, 4'b1000));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset landing on top of a read, a write and a flag load all at once.
        apply(mk("ld_r4",      1, 0, 0, 0, 1, 4, 16'h1234, 0, 4'b0000, 16'h0F0F, 16'h0F0F, 0, 4'b1000));
        apply(mk("rd_r4",      1, 1, 4, 4, 0, 0, 16'h0000, 0, 4'b0000, 16'h1234, 16'h1234, 1, 4'b1000));
        apply(mk("mid_rst",    0, 1, 4, 4, 1, 4, 16'h9999, 1, 4'b1111, 16'h0000, 16'h0000, 0, 4'b0000));
        // First cycle out of reset: read, write and flag load together.
        apply(mk("first_cyc",  1, 1, 7, 4, 1, 7, 16'h00A5, 1, 4'b0110, 16'h00A5, 16'h0000, 1, 4'b0110));
        apply(mk("post_rst",   1, 1, 4, 1, 0, 0, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0110));
        apply(mk("rd_r7",      1, 1, 7, 6, 0, 0, 16'h0000, 0, 4'b0000, 16'h00A5, 16'h0000, 1, 4'b0110));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
